// File: rtl/alu_inst_issuer.sv
// Instruction slot register file and single-entry issue buffer in front of the ALU core.
// One committed instruction is issued, its result is captured after a fixed latency and then offered over valid/ready.
module alu_inst_issuer #(
  parameter int unsigned OPERAND_WIDTH    = 8,
  parameter int unsigned INST_ADDR_LENGTH = 2,
  parameter int unsigned ALU_LATENCY      = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        writeEn,
  input  logic [INST_ADDR_LENGTH-1:0] writeAddress,
  input  logic [OPERAND_WIDTH-1:0]    inst,
  output logic [OPERAND_WIDTH-1:0]    aluOp,
  output logic [OPERAND_WIDTH-1:0]    aluA,
  output logic [OPERAND_WIDTH-1:0]    aluB,
  output logic                        aluStart,
  input  logic [OPERAND_WIDTH-1:0]    aluResult,
  input  logic [3:0]                  aluFlags,
  output logic [OPERAND_WIDTH-1:0]    result,
  output logic [3:0]                  flags,
  output logic                        resultValid,
  input  logic                        resultReady,
  output logic                        busy,
  output logic                        overrun
);

  localparam int unsigned W = OPERAND_WIDTH;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [W-1:0]   op_slot_q, op_slot_d;
  logic [W-1:0]   a_slot_q, a_slot_d;
  logic [W-1:0]   b_slot_q, b_slot_d;
  logic [3*W-1:0] pend_q, pend_d;
  logic           pend_valid_q, pend_valid_d;
  logic [W-1:0]   alu_op_q, alu_op_d;
  logic [W-1:0]   alu_a_q, alu_a_d;
  logic [W-1:0]   alu_b_q, alu_b_d;
  logic [W-1:0]   result_q, result_d;
  logic [3:0]     flags_q, flags_d;
  logic           overrun_q, overrun_d;

  logic commit;
  logic consume;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      op_slot_q    <= '0;
      a_slot_q     <= '0;
      b_slot_q     <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      result_q     <= '0;
      flags_q      <= '0;
      overrun_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      op_slot_q    <= op_slot_d;
      a_slot_q     <= a_slot_d;
      b_slot_q     <= b_slot_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      result_q     <= result_d;
      flags_q      <= flags_d;
      overrun_q    <= overrun_d;
    end
  end

  // The buffer drains whenever the FSM is free to take a new instruction this cycle.
  assign commit  = writeEn && (writeAddress == INST_ADDR_LENGTH'(2));
  assign consume = pend_valid_q &&
                   ((state_q == StIdle) || ((state_q == StDone) && resultReady));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_slot_d    = op_slot_q;
    a_slot_d     = a_slot_q;
    b_slot_d     = b_slot_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    result_d     = result_q;
    flags_d      = flags_q;
    overrun_d    = overrun_q;

    if (writeEn) begin
      if (writeAddress == INST_ADDR_LENGTH'(0)) op_slot_d = inst;
      if (writeAddress == INST_ADDR_LENGTH'(1)) a_slot_d  = inst;
      if (writeAddress == INST_ADDR_LENGTH'(2)) b_slot_d  = inst;
    end

    if (consume) begin
      pend_valid_d                  = 1'b0;
      {alu_op_d, alu_a_d, alu_b_d}  = pend_q;
    end

    // Commit captures slot values from earlier cycles plus this cycle's operand B.
    if (commit) begin
      if (!pend_valid_q || consume) begin
        pend_d       = {op_slot_q, a_slot_q, inst};
        pend_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (pend_valid_q) state_d = StIssue;
      end
      StIssue: begin
        cnt_d   = 4'(ALU_LATENCY - 1);
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == '0) begin
          result_d = aluResult;
          flags_d  = aluFlags;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        if (resultReady) state_d = pend_valid_q ? StIssue : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    aluStart    = (state_q == StIssue);
    resultValid = (state_q == StDone);
    busy        = (state_q != StIdle) || pend_valid_q;
  end

  assign aluOp   = alu_op_q;
  assign aluA    = alu_a_q;
  assign aluB    = alu_b_q;
  assign result  = result_q;
  assign flags   = flags_q;
  assign overrun = overrun_q;

endmodule
